riscv_test_monitor: RTL and testbench
=====================================

# riscv_test_monitor

Synthesizable, parametrised test-completion monitor for the RISC-V core. It snoops the core's PC and data-memory write bus, decodes riscv-tests style `tohost` writes into pass/fail, and detects self-loop halts and cycle-budget timeouts. It also captures every store into a first-word-fall-through log FIFO, so benches and FPGA harnesses get a self-checking verdict without hierarchical peeking into register file or RAM.

## Interface
- `DATA_W`, 32, width of address, data and PC buses
- `TOHOST_ADDR`, 32'h0000_1000, byte address that signals test completion
- `TIMEOUT`, 50000, cycle budget; 0 disables the timeout
- `HALT_CYCLES`, 8, consecutive cycles of unchanged PC that count as a halt (≥2)
- `LOG_DEPTH`, 16, store-log entries (power of 2, ≥2)

Ports:
- `clk` in 1: the single clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `pc` in DATA_W: core program counter
- `mem_write` in 1: data-memory write strobe
- `data_addr` in DATA_W: data-memory byte address (`alu_result`)
- `write_data` in DATA_W: store data
- `log_rd_en` in 1: pop head of store log
- `done` out 1: terminal state reached (sticky)
- `pass` out 1: `tohost` == 1 received
- `fail` out 1: odd `tohost` value ≠ 1 received
- `fail_code` out DATA_W-1: `tohost[DATA_W-1:1]` of the failing write
- `halted` out 1: self-loop detected
- `timed_out` out 1: cycle budget exhausted
- `cycle_count` out 32: cycles spent in RUN
- `store_count` out 32: stores observed in RUN
- `log_valid` out 1: log non-empty
- `log_addr`, `log_data` out DATA_W: head entry (FWFT, combinational from head)
- `log_level` out $clog2(LOG_DEPTH)+1: entries held
- `log_overflow` out 1: sticky, a store was dropped because the log was full

## Operation
- States: RUN, PASS, FAIL, HALT, TIMEOUT. Reset → RUN. All non-RUN states are terminal and sticky until `reset`.
- In RUN, per cycle, evaluated in priority order:
  - `mem_write && data_addr==TOHOST_ADDR && write_data[0]`: `write_data==1` → PASS; otherwise → FAIL with `fail_code` latched. Even values are ignored (no transition).
  - else halt counter reaches HALT_CYCLES → HALT.
  - else `TIMEOUT!=0 && cycle_count==TIMEOUT-1` → TIMEOUT.
- Halt counter:
  - `pc_prev` is registered every cycle; a valid flag is cleared by reset, so the first cycle after reset never matches.
  - `pc==pc_prev` increments the counter (saturating); any mismatch clears it to 1.
  - Transition when counter == HALT_CYCLES.
- `cycle_count` increments each RUN cycle; frozen in terminal states.
- `store_count` increments on each `mem_write` in RUN, including the terminating `tohost` write.
- Log push: every `mem_write` in RUN pushes {data_addr, write_data}, including `tohost` writes. In terminal states there are no pushes; pops remain allowed.
- Log pop: `log_rd_en && log_valid` advances head; pop when empty is ignored.
- Log full:
  - Push without pop is dropped and sets `log_overflow`.
  - Push and pop in the same cycle are both performed; level unchanged, no overflow.
- Pointers wrap modulo LOG_DEPTH.

## Timing
- Reset values: all flags 0, counters 0, `log_level` 0, `log_valid` 0, `log_addr`/`log_data` don't-care while `!log_valid`.
- Reset takes priority over any simultaneous store, pop or transition.
- Verdict latency: the `tohost` write is sampled on edge N; `done`, `pass`/`fail` and `fail_code` are valid after edge N, for 1 cycle of latency.
- Exactly one of `pass`/`fail`/`halted`/`timed_out` is high whenever `done` is high; all are low in RUN.
- Log latency: entry pushed on edge N is visible on `log_addr`/`log_data` after edge N if the log was empty.
- A reset mid-run clears log contents, state and counters in the same edge.

## Test plan
- Stores to 0x2000 (data 0xA5), 0x2004 (0x5A), then `tohost` = 1 → `pass`=1, `done`=1 one cycle later, `store_count`=3, log holds 3 entries in order, first = {0x2000, 0xA5}.
- `tohost` = 0x0000_0007 → `fail`=1, `fail_code`=3. Next, `tohost` = 0x4 → ignored, state stays RUN.
- PC held at 0x40 from cycle 10 with HALT_CYCLES=8 → `halted`=1 after the 8th matching cycle; `cycle_count` frozen afterwards.
- TIMEOUT=100, PC toggling, no `tohost` write → `timed_out`=1 with `cycle_count`=100. `tohost`=1 landing on cycle 99 → `pass` wins.
- LOG_DEPTH=4: 5 stores with no pops → `log_level`=4, `log_overflow`=1. Then a store with a simultaneous pop while full → level stays 4, head advances, no further drop.
- Assert `reset` for one cycle mid-run with 3 logged stores → all outputs return to reset values on the next edge, then a fresh `tohost`=1 produces `pass`.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// Test-completion monitor: decodes tohost writes, detects self-loop halts and timeouts,
// and keeps a first-word-fall-through log of every store observed while running.
module riscv_test_monitor #(
    parameter int unsigned        DATA_W      = 32,
    parameter logic [DATA_W-1:0]  TOHOST_ADDR = 32'h0000_1000,
    parameter int unsigned        TIMEOUT     = 50000,
    parameter int unsigned        HALT_CYCLES = 8,
    parameter int unsigned        LOG_DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          pc,
    input  logic                       mem_write,
    input  logic [DATA_W-1:0]          data_addr,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       log_rd_en,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic [DATA_W-2:0]          fail_code,
    output logic                       halted,
    output logic                       timed_out,
    output logic [31:0]                cycle_count,
    output logic [31:0]                store_count,
    output logic                       log_valid,
    output logic [DATA_W-1:0]          log_addr,
    output logic [DATA_W-1:0]          log_data,
    output logic [$clog2(LOG_DEPTH):0] log_level,
    output logic                       log_overflow
);

    localparam int unsigned PtrW  = $clog2(LOG_DEPTH);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned HaltW = $clog2(HALT_CYCLES + 1);

    localparam logic [LvlW-1:0]  LogFull     = LvlW'(LOG_DEPTH);
    localparam logic [HaltW-1:0] HaltMax     = HaltW'(HALT_CYCLES);
    localparam logic [31:0]      TimeoutLast = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {StRun, StPass, StFail, StHalt, StTimeout} state_e;

    state_e              r_state, w_state_next;
    logic [DATA_W-2:0]   r_fail_code;
    logic [DATA_W-1:0]   r_pc_prev;
    logic                r_pc_valid;
    logic [HaltW-1:0]    r_halt_cnt;
    logic [31:0]         r_cycle_count;
    logic [31:0]         r_store_count;

    logic [DATA_W-1:0]   r_log_addr [LOG_DEPTH];
    logic [DATA_W-1:0]   r_log_data [LOG_DEPTH];
    logic [PtrW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [LvlW-1:0]     r_level;
    logic                r_overflow;

    logic w_run, w_tohost_hit, w_tohost_pass;
    logic w_push_req, w_push, w_pop, w_full;

    assign w_run         = (r_state == StRun);
    // Only odd tohost values terminate; even values are ignored entirely.
    assign w_tohost_hit  = mem_write && (data_addr == TOHOST_ADDR) && write_data[0];
    assign w_tohost_pass = (write_data == DATA_W'(1));

    always_comb begin
        w_state_next = r_state;
        if (w_run) begin
            if (w_tohost_hit) begin
                w_state_next = w_tohost_pass ? StPass : StFail;
            end else if (r_halt_cnt == HaltMax) begin
                w_state_next = StHalt;
            end else if ((TIMEOUT != 0) && (r_cycle_count == TimeoutLast)) begin
                w_state_next = StTimeout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StRun;
            r_fail_code   <= '0;
            r_cycle_count <= '0;
            r_store_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_run && w_tohost_hit && !w_tohost_pass) begin
                r_fail_code <= write_data[DATA_W-1:1];
            end
            if (w_run) begin
                r_cycle_count <= r_cycle_count + 32'd1;
                if (mem_write) begin
                    r_store_count <= r_store_count + 32'd1;
                end
            end
        end
    end

    // Counter holds the number of consecutive cycles spent at the current PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_prev  <= '0;
            r_pc_valid <= 1'b0;
            r_halt_cnt <= '0;
        end else begin
            r_pc_prev  <= pc;
            r_pc_valid <= 1'b1;
            if (r_pc_valid && (pc == r_pc_prev)) begin
                if (r_halt_cnt != HaltMax) begin
                    r_halt_cnt <= r_halt_cnt + 1'b1;
                end
            end else begin
                r_halt_cnt <= HaltW'(1);
            end
        end
    end

    assign w_push_req = w_run && mem_write;
    assign w_pop      = log_rd_en && (r_level != '0);
    assign w_full     = (r_level == LogFull);
    // A simultaneous pop frees the slot, so a push into a full log still lands.
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_log_addr[r_wr_ptr] <= data_addr;
            r_log_data[r_wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign done         = !w_run;
    assign pass         = (r_state == StPass);
    assign fail         = (r_state == StFail);
    assign halted       = (r_state == StHalt);
    assign timed_out    = (r_state == StTimeout);
    assign fail_code    = r_fail_code;
    assign cycle_count  = r_cycle_count;
    assign store_count  = r_store_count;
    assign log_valid    = (r_level != '0);
    assign log_addr     = r_log_addr[r_rd_ptr];
    assign log_data     = r_log_data[r_rd_ptr];
    assign log_level    = r_level;
    assign log_overflow = r_overflow;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: verdicts, halt, timeout, log FIFO and mid-run reset.
module tb_riscv_test_monitor;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic [DW-1:0] pc;
    logic          mem_write;
    logic [DW-1:0] data_addr;
    logic [DW-1:0] write_data;
    logic          log_rd_en;
    logic          done, pass, fail, halted, timed_out, log_valid, log_overflow;
    logic [DW-2:0] fail_code;
    logic [31:0]   cycle_count, store_count;
    logic [DW-1:0] log_addr, log_data;
    logic [2:0]    log_level;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] tb_pc = 32'h100;

    riscv_test_monitor #(
        .DATA_W      (DW),
        .TOHOST_ADDR (32'h0000_1000),
        .TIMEOUT     (100),
        .HALT_CYCLES (8),
        .LOG_DEPTH   (4)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .mem_write    (mem_write),
        .data_addr    (data_addr),
        .write_data   (write_data),
        .log_rd_en    (log_rd_en),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .fail_code    (fail_code),
        .halted       (halted),
        .timed_out    (timed_out),
        .cycle_count  (cycle_count),
        .store_count  (store_count),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_level    (log_level),
        .log_overflow (log_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic [31:0] p, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rd, input logic rst);
        pc         = p;
        mem_write  = we;
        data_addr  = a;
        write_data = d;
        log_rd_en  = rd;
        reset      = rst;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        mem_write  = 1'b0;
        log_rd_en  = 1'b0;
    endtask

    task automatic idle();
        tb_pc += 4;
        cyc(tb_pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rd);
        tb_pc += 4;
        cyc(tb_pc, 1'b1, a, d, rd, 1'b0);
    endtask

    task automatic pop();
        tb_pc += 4;
        cyc(tb_pc, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        tb_pc += 4;
        cyc(tb_pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        pc = '0; mem_write = 0; data_addr = '0; write_data = '0; log_rd_en = 0; reset = 1;

        // Reset state
        do_reset();
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_cycles", cycle_count, 0);
        check("rst_stores", store_count, 0);
        check("rst_level", log_level, 0);
        check("rst_valid", log_valid, 0);
        check("rst_ovf", log_overflow, 0);

        // Two stores then tohost=1
        store(32'h2000, 32'hA5, 1'b0);
        store(32'h2004, 32'h5A, 1'b0);
        check("pre_done", done, 0);
        store(32'h1000, 32'h1, 1'b0);
        check("p_done", done, 1);
        check("p_pass", pass, 1);
        check("p_fail", fail, 0);
        check("p_stores", store_count, 3);
        check("p_cycles", cycle_count, 3);
        check("p_level", log_level, 3);
        check("p_head_a", log_addr, 32'h2000);
        check("p_head_d", log_data, 32'hA5);
        store(32'h2008, 32'h99, 1'b0);
        check("term_stores", store_count, 3);
        check("term_level", log_level, 3);
        check("term_cycles", cycle_count, 3);
        pop();
        check("pop1_a", log_addr, 32'h2004);
        check("pop1_d", log_data, 32'h5A);
        check("pop1_level", log_level, 2);
        pop();
        check("pop2_a", log_addr, 32'h1000);
        check("pop2_d", log_data, 32'h1);

        // Odd failing tohost
        do_reset();
        store(32'h1000, 32'h7, 1'b0);
        check("f_fail", fail, 1);
        check("f_pass", pass, 0);
        check("f_done", done, 1);
        check("f_code", fail_code, 3);

        // Even tohost ignored
        do_reset();
        store(32'h1000, 32'h4, 1'b0);
        check("even_done", done, 0);
        check("even_stores", store_count, 1);
        check("even_level", log_level, 1);

        // Halt: PC held at 0x40 from cycle 10
        do_reset();
        for (int i = 0; i < 10; i++) idle();
        for (int i = 0; i < 8; i++) cyc(32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("h_early", halted, 0);
        cyc(32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("h_halted", halted, 1);
        check("h_done", done, 1);
        check("h_cycles", cycle_count, 19);
        for (int i = 0; i < 3; i++) idle();
        check("h_frozen", cycle_count, 19);
        check("h_still", halted, 1);

        // Timeout at 100 cycles
        do_reset();
        for (int i = 0; i < 99; i++) idle();
        check("t_early", timed_out, 0);
        check("t_cyc99", cycle_count, 99);
        idle();
        check("t_to", timed_out, 1);
        check("t_cycles", cycle_count, 100);
        idle();
        idle();
        check("t_frozen", cycle_count, 100);

        // tohost=1 on cycle 99 beats timeout
        do_reset();
        for (int i = 0; i < 99; i++) idle();
        store(32'h1000, 32'h1, 1'b0);
        check("tp_pass", pass, 1);
        check("tp_to", timed_out, 0);

        // Log full, push+pop while full, then dropped store
        do_reset();
        for (int i = 0; i < 4; i++) store(32'h3000 + 32'(4 * i), 32'(i + 1), 1'b0);
        check("l_level4", log_level, 4);
        check("l_noovf", log_overflow, 0);
        store(32'h3100, 32'h77, 1'b1);
        check("l_pp_level", log_level, 4);
        check("l_pp_ovf", log_overflow, 0);
        check("l_pp_head", log_addr, 32'h3004);
        store(32'h3200, 32'h88, 1'b0);
        check("l_ovf", log_overflow, 1);
        check("l_ovf_level", log_level, 4);
        check("l_stores", store_count, 6);
        check("l_d0", log_data, 2);
        pop();
        check("l_d1", log_data, 3);
        pop();
        check("l_d2", log_data, 4);
        pop();
        check("l_d3_a", log_addr, 32'h3100);
        check("l_d3_d", log_data, 32'h77);
        check("l_lvl1", log_level, 1);
        pop();
        check("l_empty", log_valid, 0);
        pop();
        check("l_empty_pop", log_level, 0);

        // Mid-run reset with a simultaneous tohost store
        do_reset();
        for (int i = 0; i < 3; i++) store(32'h4000 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
        check("m_level", log_level, 3);
        tb_pc += 4;
        cyc(tb_pc, 1'b1, 32'h1000, 32'h1, 1'b1, 1'b1);
        check("m_done", done, 0);
        check("m_pass", pass, 0);
        check("m_level0", log_level, 0);
        check("m_valid", log_valid, 0);
        check("m_stores", store_count, 0);
        check("m_cycles", cycle_count, 0);
        store(32'h1000, 32'h1, 1'b0);
        check("m_pass2", pass, 1);
        check("m_stores2", store_count, 1);
        check("m_head", log_addr, 32'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
